// File: rtl/load_store_unit.sv
// Load/store unit: decodes core memory ops into aligned word bus transactions,
// lane-extracts and extends load data, and faults on illegal, misaligned or timed-out accesses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    input  logic        mem_write_enable_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        store_done_o,
    output logic        fault_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;

    logic        legal, misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] lane;
    logic [31:0] load_ext;

    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b0000;
        wdata_new  = store_data_i;
        case (funct3_i)
            3'b000, 3'b100: begin
                legal     = !(funct3_i[2] && mem_write_enable_i);
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{store_data_i[7:0]}};
            end
            3'b001, 3'b101: begin
                legal      = !(funct3_i[2] && mem_write_enable_i);
                misaligned = addr_i[0];
                be_new     = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{store_data_i[15:0]}};
            end
            3'b010: begin
                legal      = 1'b1;
                misaligned = (addr_i[1:0] != 2'b00);
                be_new     = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend by the latched funct3.
    always_comb begin
        lane = bus_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'h0, lane[15:0]};
            default: load_ext = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        off_d       = off_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        load_data_d = load_data_q;
        fault_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (!legal || misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        addr_d   = {addr_i[31:2], 2'b00};
                        off_d    = addr_i[1:0];
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        we_d     = mem_write_enable_i;
                        funct3_d = funct3_i;
                        tmo_d    = '0;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle wins over the timeout.
                if (bus_ack_i) begin
                    state_d = RESP;
                    if (!we_q) load_data_d = load_ext;
                end else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            addr_q      <= '0;
            off_q       <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign bus_req_o    = (state_q == ACCESS);
    assign bus_we_o     = (state_q == ACCESS) && we_q;
    assign bus_addr_o   = addr_q;
    assign bus_wdata_o  = wdata_q;
    assign bus_be_o     = be_q;
    assign load_valid_o = (state_q == RESP) && !we_q;
    assign store_done_o = (state_q == RESP) && we_q;
    assign load_data_o  = load_data_q;
    assign fault_o      = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and reset abort.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] sdata = '0;
    logic        busy, load_valid, store_done, fault;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid),
        .mem_write_enable_i(we), .funct3_i(f3), .addr_i(addr),
        .store_data_i(sdata), .busy_o(busy), .load_data_o(load_data),
        .load_valid_o(load_valid), .store_done_o(store_done), .fault_o(fault),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_be_o(bus_be), .bus_ack_i(ack),
        .bus_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
            $error("%s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Status bundle {busy, bus_req, bus_we, load_valid, store_done, fault}
    function automatic logic [31:0] st();
        return {26'h0, busy, bus_req, bus_we, load_valid, store_done, fault};
    endfunction

    initial begin
        tick(); tick();
        chk("rst_status", st(), 32'h00);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_be", {28'h0, bus_be}, 32'h0);
        chk("rst_ldata", load_data, 32'h0);
        rst_n = 1'b1;
        tick();

        // LB 0x103, ack in first ACCESS cycle
        req_valid = 1; we = 0; f3 = 3'b000; addr = 32'h103;
        tick();
        req_valid = 0;
        chk("lb_status", st(), 32'h30);
        chk("lb_addr", bus_addr, 32'h100);
        chk("lb_be", {28'h0, bus_be}, 32'h8);
        ack = 1; rdata = 32'h80FF_1234;
        tick();
        ack = 0;
        chk("lb_resp", st(), 32'h24);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        tick();
        chk("lb_after", st(), 32'h00);
        chk("lb_hold", load_data, 32'hFFFF_FF80);

        // SH 0x202, three wait cycles then ack
        req_valid = 1; we = 1; f3 = 3'b001; addr = 32'h202; sdata = 32'hDEAD_BEEF;
        tick();
        req_valid = 0; sdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("sh_status", st(), 32'h38);
            chk("sh_be", {28'h0, bus_be}, 32'hC);
            chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
            chk("sh_addr", bus_addr, 32'h200);
            if (i < 3) tick();
        end
        ack = 1;
        tick();
        ack = 0;
        chk("sh_done", st(), 32'h22);
        tick();
        chk("sh_after", st(), 32'h00);

        // Misaligned LW and illegal store funct3=100
        req_valid = 1; we = 0; f3 = 3'b010; addr = 32'h006;
        tick();
        req_valid = 0;
        chk("lw_mis_fault", st(), 32'h01);
        tick();
        chk("lw_mis_after", st(), 32'h00);
        req_valid = 1; we = 1; f3 = 3'b100; addr = 32'h000;
        tick();
        req_valid = 0; we = 0;
        chk("sbu_fault", st(), 32'h01);
        tick();
        chk("sbu_after", st(), 32'h00);

        // LHU 0x002 with no ack: timeout after 4 ACCESS cycles
        req_valid = 1; f3 = 3'b101; addr = 32'h002;
        tick();
        req_valid = 0;
        chk("lhu_be", {28'h0, bus_be}, 32'hC);
        for (int i = 0; i < 4; i++) begin
            chk("lhu_wait", st(), 32'h30);
            if (i < 3) tick();
        end
        tick();
        chk("lhu_timeout", st(), 32'h01);
        tick();
        chk("lhu_to_after", st(), 32'h00);

        // LHU again, ack on the 4th cycle beats the timeout
        req_valid = 1;
        tick();
        req_valid = 0;
        tick(); tick(); tick();
        chk("lhu2_c4", st(), 32'h30);
        ack = 1; rdata = 32'h8001_0000;
        tick();
        ack = 0;
        chk("lhu2_resp", st(), 32'h24);
        chk("lhu2_data", load_data, 32'h0000_8001);
        tick();
        chk("lhu2_after", st(), 32'h00);

        // Reset during ACCESS, then a late ack
        req_valid = 1; f3 = 3'b010; addr = 32'h010;
        tick();
        req_valid = 0;
        chk("rstmid_access", st(), 32'h30);
        rst_n = 0;
        tick();
        chk("rstmid_idle", st(), 32'h00);
        rst_n = 1; ack = 1; rdata = 32'hFFFF_FFFF;
        tick();
        ack = 0;
        chk("rstmid_lateack", st(), 32'h00);
        tick();
        chk("rstmid_quiet", st(), 32'h00);
        chk("rstmid_ldata", load_data, 32'h0);

        // LBU 0x001 after the abort is served normally
        req_valid = 1; f3 = 3'b100; addr = 32'h001;
        tick();
        req_valid = 0;
        chk("lbu_be", {28'h0, bus_be}, 32'h2);
        ack = 1; rdata = 32'h0000_AB00;
        tick();
        ack = 0;
        chk("lbu_resp", st(), 32'h24);
        chk("lbu_data", load_data, 32'h0000_00AB);
        tick();

        // req_valid held high across a whole transfer
        req_valid = 1; f3 = 3'b010; addr = 32'h020;
        tick();
        chk("hold_access", st(), 32'h30);
        tick();
        chk("hold_wait", st(), 32'h30);
        ack = 1; rdata = 32'h1234_5678;
        tick();
        ack = 0;
        chk("hold_resp", st(), 32'h24);
        chk("hold_data", load_data, 32'h1234_5678);
        tick();
        req_valid = 0;
        chk("hold_idle", st(), 32'h00);
        tick();
        chk("hold_no_reissue", st(), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end
endmodule
